// File: rtl/apb_pkg.sv
// Shared FSM encoding, default widths and sizing helper for the APB command master.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam int APB_ADDR_WIDTH     = 10;
  localparam int APB_DATA_WIDTH     = 32;
  localparam int APB_NUM_SLAVES     = 4;
  localparam int APB_SEL_LSB        = 8;
  localparam int APB_TIMEOUT_CYCLES = 16;

  // Bits needed to index n items; never less than one so a single slave still gets a field.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/apb_slave_decode.sv
// Combinational address decode: slave index field -> one-hot select plus out-of-range flag.
module apb_slave_decode
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int NUM_SLAVES = APB_NUM_SLAVES,
  parameter int SEL_LSB    = APB_SEL_LSB
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  dec_err
);

  localparam int SEL_W = clog2_min1(NUM_SLAVES);

  logic [SEL_W-1:0] idx_s;
  logic             unused_addr_s;

  assign idx_s         = addr[SEL_LSB +: SEL_W];
  assign unused_addr_s = ^addr;

  // A lone slave owns the whole space, so its select never depends on the index field.
  always_comb begin
    sel     = '0;
    dec_err = 1'b0;
    if (NUM_SLAVES == 1) begin
      sel = '1;
    end else if (int'(idx_s) >= NUM_SLAVES) begin
      dec_err = 1'b1;
    end else begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        sel[i] = (idx_s == SEL_W'(i));
      end
    end
  end

endmodule

// File: rtl/apb_cmd_master.sv
// APB master turning a valid/ready command stream into APB transfers with a valid/ready response.
// Optional wait-state timeout is built when APB_TIMEOUT_EN is defined.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int NUM_SLAVES     = APB_NUM_SLAVES,
  parameter int SEL_LSB        = APB_SEL_LSB,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic                    pwrite,
  output logic [NUM_SLAVES-1:0]   psel,
  output logic                    penable,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;

  apb_state_e            state_r;
  apb_state_e            state_nxt_s;
  logic                  req_ready_nxt_s;
  logic [ADDR_WIDTH-1:0] paddr_nxt_s;
  logic [DATA_WIDTH-1:0] pwdata_nxt_s;
  logic [STRB_W-1:0]     pstrb_nxt_s;
  logic                  pwrite_nxt_s;
  logic [NUM_SLAVES-1:0] psel_nxt_s;
  logic                  penable_nxt_s;
  logic                  rsp_valid_nxt_s;
  logic [DATA_WIDTH-1:0] rsp_rdata_nxt_s;
  logic                  rsp_err_nxt_s;
  logic [NUM_SLAVES-1:0] dec_sel_s;
  logic                  dec_err_s;
  logic                  timeout_s;

  apb_slave_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_LSB    (SEL_LSB)
  ) u_decode (
    .addr    (req_addr),
    .sel     (dec_sel_s),
    .dec_err (dec_err_s)
  );

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = clog2_min1(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wait_cnt_r;

  // Counts pready-low cycles of the current ACCESS phase; idle outside ACCESS.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_cnt_r <= '0;
    end else if (state_r != ACCESS) begin
      wait_cnt_r <= '0;
    end else if (!pready) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  assign timeout_s = (state_r == ACCESS) && !pready &&
                     (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_s;

  assign unused_timeout_s = (TIMEOUT_CYCLES > 0);
  assign timeout_s        = 1'b0;
`endif

  // Next-state and next-output logic; every output is a register fed from here.
  always_comb begin
    state_nxt_s     = state_r;
    req_ready_nxt_s = 1'b0;
    paddr_nxt_s     = paddr;
    pwdata_nxt_s    = pwdata;
    pstrb_nxt_s     = pstrb;
    pwrite_nxt_s    = pwrite;
    psel_nxt_s      = psel;
    penable_nxt_s   = penable;
    rsp_valid_nxt_s = rsp_valid;
    rsp_rdata_nxt_s = rsp_rdata;
    rsp_err_nxt_s   = rsp_err;
    case (state_r)
      IDLE: begin
        if (req_valid && req_ready) begin
          if (dec_err_s) begin
            state_nxt_s     = RESP;
            rsp_valid_nxt_s = 1'b1;
            rsp_err_nxt_s   = 1'b1;
            rsp_rdata_nxt_s = '0;
          end else begin
            state_nxt_s  = SETUP;
            psel_nxt_s   = dec_sel_s;
            paddr_nxt_s  = req_addr;
            pwrite_nxt_s = req_write;
            pwdata_nxt_s = req_wdata;
            pstrb_nxt_s  = req_write ? req_strb : '0;
          end
        end else begin
          req_ready_nxt_s = 1'b1;
        end
      end
      SETUP: begin
        state_nxt_s   = ACCESS;
        penable_nxt_s = 1'b1;
      end
      ACCESS: begin
        if (pready) begin
          state_nxt_s     = RESP;
          psel_nxt_s      = '0;
          penable_nxt_s   = 1'b0;
          rsp_valid_nxt_s = 1'b1;
          rsp_err_nxt_s   = pslverr;
          rsp_rdata_nxt_s = (pwrite || pslverr) ? '0 : prdata;
        end else if (timeout_s) begin
          state_nxt_s     = RESP;
          psel_nxt_s      = '0;
          penable_nxt_s   = 1'b0;
          rsp_valid_nxt_s = 1'b1;
          rsp_err_nxt_s   = 1'b1;
          rsp_rdata_nxt_s = '0;
        end else begin
          state_nxt_s = ACCESS;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt_s     = IDLE;
          rsp_valid_nxt_s = 1'b0;
          req_ready_nxt_s = 1'b1;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s     = IDLE;
        psel_nxt_s      = '0;
        penable_nxt_s   = 1'b0;
        rsp_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer without a response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= IDLE;
      req_ready <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      pwrite    <= 1'b0;
      psel      <= '0;
      penable   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      req_ready <= req_ready_nxt_s;
      paddr     <= paddr_nxt_s;
      pwdata    <= pwdata_nxt_s;
      pstrb     <= pstrb_nxt_s;
      pwrite    <= pwrite_nxt_s;
      psel      <= psel_nxt_s;
      penable   <= penable_nxt_s;
      rsp_valid <= rsp_valid_nxt_s;
      rsp_rdata <= rsp_rdata_nxt_s;
      rsp_err   <= rsp_err_nxt_s;
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed self-checking bench for apb_cmd_master (4-slave and 3-slave instances), scoreboarded responses.
module tb_apb_cmd_master;
  import apb_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] rdata;
  } rsp_t;

  logic clk;
  logic resetn;

  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_strb;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic [SW-1:0] pstrb;
  logic          pwrite, penable, pready, pslverr;
  logic [3:0]    psel;

  logic          d3_req_valid, d3_req_ready, d3_req_write;
  logic [AW-1:0] d3_req_addr;
  logic [DW-1:0] d3_req_wdata;
  logic [SW-1:0] d3_req_strb;
  logic          d3_rsp_valid, d3_rsp_ready, d3_rsp_err;
  logic [DW-1:0] d3_rsp_rdata;
  logic [AW-1:0] d3_paddr;
  logic [DW-1:0] d3_pwdata, d3_prdata;
  logic [SW-1:0] d3_pstrb;
  logic          d3_pwrite, d3_penable, d3_pready, d3_pslverr;
  logic [2:0]    d3_psel;

  rsp_t sb[$];
  rsp_t sb3[$];
  int   checks = 0;
  int   errors = 0;

  apb_cmd_master u_dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pwrite(pwrite),
    .psel(psel), .penable(penable), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  apb_cmd_master #(.NUM_SLAVES(3)) u_dut3 (
    .clk(clk), .resetn(resetn),
    .req_valid(d3_req_valid), .req_ready(d3_req_ready), .req_write(d3_req_write),
    .req_addr(d3_req_addr), .req_wdata(d3_req_wdata), .req_strb(d3_req_strb),
    .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready), .rsp_rdata(d3_rsp_rdata), .rsp_err(d3_rsp_err),
    .paddr(d3_paddr), .pwdata(d3_pwdata), .pstrb(d3_pstrb), .pwrite(d3_pwrite),
    .psel(d3_psel), .penable(d3_penable), .pready(d3_pready), .prdata(d3_prdata), .pslverr(d3_pslverr)
  );

  always #5 clk = ~clk;

  function automatic rsp_t mk(input logic e, input logic [DW-1:0] d);
    rsp_t r;
    r.err   = e;
    r.rdata = d;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [SW-1:0] st, input rsp_t exp);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    req_strb  = st;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    sb.push_back(exp);
    step();
    req_valid = 1'b0;
    req_addr  = ~a;
    req_wdata = ~wd;
    req_strb  = ~st;
  endtask

  task automatic wait_rsp(input string tag, input int exp_lat);
    int   n;
    rsp_t e;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_sb_size"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_err"}, 32'(rsp_err), 32'(e.err));
      check({tag, "_rdata"}, rsp_rdata, e.rdata);
    end
    check({tag, "_psel_off"}, 32'(psel), 32'd0);
    check({tag, "_penable_off"}, 32'(penable), 32'd0);
  endtask

  task automatic ack(input string tag);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rsp_t e3;
    clk = 1'b0;
    resetn = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_strb = '0;
    rsp_ready = 1'b0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    d3_req_valid = 1'b0; d3_req_write = 1'b0; d3_req_addr = '0; d3_req_wdata = '0; d3_req_strb = '0;
    d3_rsp_ready = 1'b0; d3_pready = 1'b0; d3_prdata = '0; d3_pslverr = 1'b0;

    // Reset state
    #2 resetn = 1'b0;
    #1;
    check("rst_psel", 32'(psel), 32'd0);
    check("rst_penable", 32'(penable), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_paddr", 32'(paddr), 32'd0);
    check("rst_pwrite", 32'(pwrite), 32'd0);
    repeat (2) step();
    resetn = 1'b1;
    step();
    check("idle_req_ready", 32'(req_ready), 32'd1);

    // Write, zero waits; pready and pslverr high during SETUP must be ignored
    pready = 1'b1;
    issue(1'b1, 10'h104, 32'hDEADBEEF, 4'hF, mk(1'b0, 32'h0));
    pslverr = 1'b1;
    check("wr_setup_psel", 32'(psel), 32'h2);
    check("wr_setup_penable", 32'(penable), 32'd0);
    check("wr_setup_pwrite", 32'(pwrite), 32'd1);
    check("wr_setup_pstrb", 32'(pstrb), 32'hF);
    check("wr_setup_paddr", 32'(paddr), 32'h104);
    check("wr_setup_pwdata", pwdata, 32'hDEADBEEF);
    check("wr_setup_req_ready", 32'(req_ready), 32'd0);
    step();
    pslverr = 1'b0;
    check("wr_access_penable", 32'(penable), 32'd1);
    check("wr_access_psel", 32'(psel), 32'h2);
    check("wr_access_paddr", 32'(paddr), 32'h104);
    wait_rsp("wr", 1);
    ack("wr");

    // Read with three wait states: response four cycles after ACCESS starts
    pready = 1'b0;
    issue(1'b0, 10'h3F0, 32'h0, 4'hF, mk(1'b0, 32'h12345678));
    check("rd_setup_psel", 32'(psel), 32'h8);
    check("rd_setup_pstrb", 32'(pstrb), 32'h0);
    check("rd_setup_pwrite", 32'(pwrite), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("rd_wait_psel", 32'(psel), 32'h8);
      check("rd_wait_penable", 32'(penable), 32'd1);
      check("rd_wait_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    pready = 1'b1;
    prdata = 32'h12345678;
    wait_rsp("rd_wait", 1);
    prdata = 32'hFFFF0000;
    ack("rd_wait");

    // Slave error on read, then five cycles of response back-pressure with a pending command
    pslverr = 1'b1;
    prdata  = 32'h0;
    issue(1'b0, 10'h010, 32'h0, 4'hF, mk(1'b1, 32'h0));
    check("rderr_setup_psel", 32'(psel), 32'h1);
    step();
    wait_rsp("rderr", 1);
    pslverr = 1'b0;
    prdata = 32'h77777777;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h000; req_wdata = 32'h1; req_strb = 4'h1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_rsp_err", 32'(rsp_err), 32'd1);
      check("hold_rsp_rdata", rsp_rdata, 32'h0);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_psel", 32'(psel), 32'd0);
    end
    req_valid = 1'b0;
    ack("rderr");

    // Reset during ACCESS aborts immediately without a response
    pready = 1'b0;
    issue(1'b1, 10'h204, 32'hA5A5A5A5, 4'h3, mk(1'b0, 32'h0));
    step();
    check("pre_rst_psel", 32'(psel), 32'h4);
    check("pre_rst_penable", 32'(penable), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("midrst_psel", 32'(psel), 32'd0);
    check("midrst_penable", 32'(penable), 32'd0);
    check("midrst_paddr", 32'(paddr), 32'd0);
    check("midrst_pwdata", pwdata, 32'd0);
    check("midrst_pstrb", 32'(pstrb), 32'd0);
    check("midrst_pwrite", 32'(pwrite), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    sb.delete();
    repeat (2) step();
    resetn = 1'b1;
    step();
    check("postrst_req_ready", 32'(req_ready), 32'd1);
    check("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
    pready = 1'b1;
    issue(1'b1, 10'h0FC, 32'h0BADF00D, 4'h5, mk(1'b0, 32'h0));
    check("postrst_psel", 32'(psel), 32'h1);
    check("postrst_pstrb", 32'(pstrb), 32'h5);
    check("postrst_pwdata", pwdata, 32'h0BADF00D);
    wait_rsp("postrst_wr", 2);
    ack("postrst_wr");

`ifdef APB_TIMEOUT_EN
    // Stuck slave: terminated after TIMEOUT_CYCLES ACCESS cycles, late pready ignored
    pready = 1'b0;
    prdata = 32'h55AA55AA;
    issue(1'b0, 10'h108, 32'h0, 4'hF, mk(1'b1, 32'h0));
    wait_rsp("timeout", 1 + APB_TIMEOUT_CYCLES);
    pready = 1'b1;
    step();
    check("timeout_rsp_held", 32'(rsp_valid), 32'd1);
    check("timeout_no_psel", 32'(psel), 32'd0);
    ack("timeout");
`else
    // Without timeout the master waits as long as the slave stalls
    pready = 1'b0;
    issue(1'b0, 10'h108, 32'h0, 4'hF, mk(1'b0, 32'hC0FFEE11));
    repeat (20) step();
    check("longwait_penable", 32'(penable), 32'd1);
    check("longwait_psel", 32'(psel), 32'h2);
    check("longwait_rsp_valid", 32'(rsp_valid), 32'd0);
    pready = 1'b1;
    prdata = 32'hC0FFEE11;
    wait_rsp("longwait", 1);
    ack("longwait");
`endif

    // Three-slave instance: index 3 is a decode error with no APB cycle
    d3_req_valid = 1'b1; d3_req_write = 1'b0; d3_req_addr = 10'h300;
    check("d3_req_ready", 32'(d3_req_ready), 32'd1);
    sb3.push_back(mk(1'b1, 32'h0));
    step();
    d3_req_valid = 1'b0;
    check("d3_dec_rsp_valid", 32'(d3_rsp_valid), 32'd1);
    check("d3_dec_psel", 32'(d3_psel), 32'd0);
    check("d3_dec_penable", 32'(d3_penable), 32'd0);
    check("d3_dec_sb_size", 32'(sb3.size()), 32'd1);
    if (sb3.size() > 0) begin
      e3 = sb3.pop_front();
      check("d3_dec_err", 32'(d3_rsp_err), 32'(e3.err));
      check("d3_dec_rdata", d3_rsp_rdata, e3.rdata);
    end
    d3_rsp_ready = 1'b1;
    step();
    d3_rsp_ready = 1'b0;
    check("d3_dec_rsp_drop", 32'(d3_rsp_valid), 32'd0);
    check("d3_dec_no_psel", 32'(d3_psel), 32'd0);

    // Three-slave instance: index 2 completes normally
    d3_pready = 1'b1;
    d3_prdata = 32'hCAFE0001;
    d3_req_valid = 1'b1; d3_req_addr = 10'h200;
    check("d3_req_ready2", 32'(d3_req_ready), 32'd1);
    sb3.push_back(mk(1'b0, 32'hCAFE0001));
    step();
    d3_req_valid = 1'b0;
    check("d3_setup_psel", 32'(d3_psel), 32'h4);
    repeat (2) step();
    check("d3_rd_rsp_valid", 32'(d3_rsp_valid), 32'd1);
    check("d3_rd_sb_size", 32'(sb3.size()), 32'd1);
    if (sb3.size() > 0) begin
      e3 = sb3.pop_front();
      check("d3_rd_err", 32'(d3_rsp_err), 32'(e3.err));
      check("d3_rd_rdata", d3_rsp_rdata, e3.rdata);
    end
    d3_rsp_ready = 1'b1;
    step();
    d3_rsp_ready = 1'b0;
    check("d3_rd_rsp_drop", 32'(d3_rsp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
